cone_scan_driver: RTL and testbench
===================================

# cone_scan_driver

Sequential stimulus/response driver for an extracted combinational cone from the sequential benchmark netlists, such as a single partial-output cone of s9234. The driver re-supplies the state side that combinational extraction removed:
- shifts a pattern into a register and holds it steady on the cone's inputs;
- waits a settle window, samples the cone's single output, and compacts responses into a MISR signature.

It sits between the bench/ATE-style serial source and the cone instance.

## Interface
Parameters:
- N_IN, 23, cone input width (pattern length)
- SIG_W, 16, signature width
- SIG_POLY, 16'hB400, Galois MISR feedback mask (x^16+x^14+x^13+x^11+1)
- SIG_SEED, 16'h0000, signature value loaded at reset and at session start
- SETTLE, 2, cycles pi_vec is held before capture (min 1)

Ports (identical in both builds):
- CK  in  1  clock, rising edge
- RN  in  1  reset, asynchronous, active-low
- start  in  1  session start; sampled only in IDLE
- num_pat  in  16  pattern count; latched on accepted start
- scan_in  in  1  serial pattern bit
- scan_valid  in  1  scan_in valid
- scan_ready  out  1  driver accepts a bit (SHIFT state only)
- pi_vec  out  N_IN  pattern applied to the cone inputs
- cone_out  in  1  cone output
- resp_out  out  1  last captured cone_out
- resp_valid  out  1  one-cycle pulse per capture
- signature  out  SIG_W  MISR state
- pat_cnt  out  16  patterns captured this session
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at session end

## Operation
FSM states: IDLE, SHIFT, APPLY, CAPTURE, DONE.

- **IDLE**
  - On start=1 with num_pat≠0: latch num_pat, set signature=SIG_SEED, pat_cnt=0, go to SHIFT.
  - On start=1 with num_pat=0: set signature=SIG_SEED, go to DONE.
- **SHIFT**
  - scan_ready=1. A bit is transferred when scan_valid && scan_ready.
  - Shift register shifts right; scan_in enters bit N_IN-1. Bits therefore arrive LSB first, and after N_IN transfers the first bit sits in bit 0.
  - The N_IN-th transfer loads pi_vec from the completed word (shift register with that bit included) and moves to APPLY. The bit counter then clears.
  - Gaps in scan_valid stall the shift without losing state.
- **APPLY**
  - pi_vec held constant; wait SETTLE cycles, then go to CAPTURE.
- **CAPTURE** (1 cycle)
  - fb = signature[0] ^ cone_out.
  - signature <= (signature >> 1) ^ (fb ? SIG_POLY : 0).
  - resp_out <= cone_out; resp_valid pulses; pat_cnt increments.
  - If the new pat_cnt equals the latched num_pat, go to DONE; otherwise go to SHIFT.
- **DONE**
  - done=1 for one cycle, then return to IDLE.
  - signature, pat_cnt, pi_vec and resp_out hold until the next accepted start.

Other rules:
- start outside IDLE is ignored.
- pi_vec changes only on SHIFT→APPLY (or GEN→APPLY in the LFSR build), never during APPLY or CAPTURE.

## Timing
- **Reset values:** state=IDLE, pi_vec=0, signature=SIG_SEED, pat_cnt=0, resp_out=0, and scan_ready, resp_valid, busy, done all 0.
- **Reset mid-session:** everything returns to the reset values immediately. No done pulse is produced, and the partial pattern is discarded.
- **Per-pattern latency** with continuous scan_valid is N_IN + SETTLE + 1 cycles (26 at defaults).
- **done timing:** done asserts the cycle after the final CAPTURE.
- **Capture path:** cone_out is sampled at the CAPTURE edge. The cone path gets SETTLE+1 cycles from pi_vec.
- **pat_cnt wrap:** pat_cnt wraps at 16 bits. num_pat=65535 completes normally.

## Configuration
- **BIST_LFSR_EN** defined:
  - SHIFT is replaced by a one-cycle GEN state.
  - GEN loads pi_vec with an internal N_IN-bit Galois LFSR, then advances it with mask 23'h420000 (x^23+x^18+1) and seed 23'h000001.
  - The LFSR is reloaded at each accepted start.
  - scan_ready is tied 0; scan_in and scan_valid are ignored.
  - Per-pattern latency is 1 + SETTLE + 1 cycles (4 at defaults).
- **BIST_LFSR_EN** undefined: serial shift only, and no LFSR logic is present.

## Test plan
- **Single pattern:** RN low then high; num_pat=1, cone_out tied 1, 23 continuous bits. Required: pi_vec stable, resp_valid once with resp_out=1, signature=16'hB400, pat_cnt=1, done 27 cycles after start.
- **Two patterns:** num_pat=2, cone_out=1 on the first capture and 0 on the second. Required: signature=16'h5A00, pat_cnt=2, exactly two resp_valid pulses.
- **Bit order and backpressure:** shift 23'h123456 LSB first with random scan_valid gaps. Required: pi_vec==23'h123456 on APPLY entry, and no bit is lost or duplicated.
- **Zero-pattern session and start in busy:** start with num_pat=0. Required: done the next cycle, signature=SIG_SEED, scan_ready never high. Also, start pulsed during APPLY has no effect.
- **Reset mid-session:** RN low during APPLY of pattern 3. Required: all outputs at reset values asynchronously and no done pulse. A new session then behaves exactly as the single-pattern case.
- **LFSR build (BIST_LFSR_EN):** num_pat=2. Required: pi_vec=23'h000001 for pattern 1 and 23'h420000 for pattern 2, scan_ready stays 0, done 9 cycles after start.

Source files
------------

// File: rtl/cone_scan_driver.sv
// cone_scan_driver: loads a pattern onto an extracted combinational cone, waits
// for it to settle, captures the cone output and folds it into a MISR signature.
// Optional build macro BIST_LFSR_EN swaps the serial pattern load for an internal LFSR.
module cone_scan_driver #(
    parameter int               N_IN     = 23,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 16'hB400,
    parameter logic [SIG_W-1:0] SIG_SEED = 16'h0000,
    parameter int               SETTLE   = 2
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic [15:0]      num_pat,
    input  logic             scan_in,
    input  logic             scan_valid,
    output logic             scan_ready,
    output logic [N_IN-1:0]  pi_vec,
    input  logic             cone_out,
    output logic             resp_out,
    output logic             resp_valid,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      pat_cnt,
    output logic             busy,
    output logic             done
);

    localparam int BW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [BW-1:0] LAST_BIT    = BW'(N_IN - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_APPLY   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_GEN     = 3'd5;

    logic [2:0]       state;
    logic [15:0]      num_lat;
    logic [SW-1:0]    settle_cnt;
    logic [SIG_W-1:0] sig_next;
    logic             fb;

    assign fb       = signature[0] ^ cone_out;
    assign sig_next = (signature >> 1) ^ (fb ? SIG_POLY : '0);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

`ifdef BIST_LFSR_EN
    localparam logic [2:0]      S_LOAD     = S_GEN;
    localparam logic [N_IN-1:0] LFSR_POLY  = N_IN'(23'h420000);
    localparam logic [N_IN-1:0] LFSR_SEED  = N_IN'(23'h000001);
    logic [N_IN-1:0] lfsr;
    logic [N_IN-1:0] lfsr_next;

    assign lfsr_next  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
    assign scan_ready = 1'b0;
`else
    localparam logic [2:0] S_LOAD = S_SHIFT;
    logic [N_IN-1:0] sreg;
    logic [N_IN-1:0] shift_word;
    logic [BW-1:0]   bit_cnt;

    // Valid/ready: a bit moves on a rising CK edge where scan_valid and
    // scan_ready are both high; scan_valid may drop at any time, stalling the load.
    assign scan_ready = (state == S_SHIFT);
    assign shift_word = {scan_in, sreg[N_IN-1:1]};
`endif

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state      <= S_IDLE;
            pi_vec     <= '0;
            signature  <= SIG_SEED;
            pat_cnt    <= '0;
            resp_out   <= 1'b0;
            resp_valid <= 1'b0;
            num_lat    <= '0;
            settle_cnt <= '0;
`ifdef BIST_LFSR_EN
            lfsr       <= LFSR_SEED;
`else
            sreg       <= '0;
            bit_cnt    <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        signature <= SIG_SEED;
                        if (num_pat != 16'd0) begin
                            num_lat <= num_pat;
                            pat_cnt <= '0;
                            state   <= S_LOAD;
`ifdef BIST_LFSR_EN
                            lfsr    <= LFSR_SEED;
`endif
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
`ifdef BIST_LFSR_EN
                S_GEN: begin
                    pi_vec <= lfsr;
                    lfsr   <= lfsr_next;
                    state  <= S_APPLY;
                end
`else
                S_SHIFT: begin
                    if (scan_valid) begin
                        sreg <= shift_word;
                        // The final bit is taken straight from the input so the
                        // whole word reaches pi_vec on the same edge.
                        if (bit_cnt == LAST_BIT) begin
                            pi_vec  <= shift_word;
                            bit_cnt <= '0;
                            state   <= S_APPLY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`endif
                S_APPLY: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        settle_cnt <= '0;
                        state      <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    signature  <= sig_next;
                    resp_out   <= cone_out;
                    resp_valid <= 1'b1;
                    pat_cnt    <= pat_cnt + 16'd1;
                    state      <= (pat_cnt + 16'd1 == num_lat) ? S_DONE : S_LOAD;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cone_scan_driver.sv
// Bench for cone_scan_driver: vector table of sessions, randomized sessions
// against a reference MISR model, plus reset, zero-pattern and busy-start sequences.
module tb_cone_scan_driver;

    localparam int          N_IN   = 23;
    localparam int          SIG_W  = 16;
    localparam int          SETTLE = 2;
    localparam logic [15:0] POLY   = 16'hB400;
    localparam logic [15:0] SEED   = 16'h0000;

    logic             CK = 1'b0;
    logic             RN = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      num_pat = 16'd0;
    logic             scan_in = 1'b0;
    logic             scan_valid = 1'b0;
    logic             scan_ready;
    logic [N_IN-1:0]  pi_vec;
    logic             cone_out = 1'b0;
    logic             resp_out;
    logic             resp_valid;
    logic [SIG_W-1:0] signature;
    logic [15:0]      pat_cnt;
    logic             busy;
    logic             done;

    cone_scan_driver #(
        .N_IN(N_IN), .SIG_W(SIG_W), .SIG_POLY(POLY), .SIG_SEED(SEED), .SETTLE(SETTLE)
    ) dut (
        .CK(CK), .RN(RN), .start(start), .num_pat(num_pat),
        .scan_in(scan_in), .scan_valid(scan_valid), .scan_ready(scan_ready),
        .pi_vec(pi_vec), .cone_out(cone_out), .resp_out(resp_out),
        .resp_valid(resp_valid), .signature(signature), .pat_cnt(pat_cnt),
        .busy(busy), .done(done)
    );

    // clock / reset
    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // scoreboard
    int              checks = 0;
    int              errors = 0;
    logic [N_IN-1:0] exp_q[$];
    logic [N_IN-1:0] pat_mem[8];
    logic            cone_mem[8];

    typedef struct {
        int          n;
        logic [3:0]  cone;
        bit          gap;
        bit          poke;
        logic [15:0] exp_sig;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One response bit divided into the signature polynomial.
    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic b);
        logic [15:0] r;
        r = s >> 1;
        if (s[0] ^ b) r = r ^ POLY;
        return r;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pi_vec"}, 32'(pi_vec), 32'd0);
        chk({tag, "_signature"}, 32'(signature), 32'(SEED));
        chk({tag, "_pat_cnt"}, 32'(pat_cnt), 32'd0);
        chk({tag, "_resp_out"}, 32'(resp_out), 32'd0);
        chk({tag, "_flags"}, 32'({scan_ready, resp_valid, busy, done}), 32'd0);
    endtask

    // driver: one session of n patterns from pat_mem/cone_mem
    task automatic run_session(input int n, input bit gap, input bit poke, input int abort_p);
        int              c0;
        int              i;
        int              guard;
        bit              rdy;
        logic [N_IN-1:0] want;
        logic [15:0]     msig;
        msig = SEED;
        @(negedge CK);
        start   = 1'b1;
        num_pat = 16'(n);
        c0      = cyc;
        @(negedge CK);
        start = 1'b0;
        for (int p = 0; p < n; p++) begin
            exp_q.push_back(pat_mem[p]);
            i = 0;
            guard = 0;
            while (i < N_IN && guard < 400) begin
                rdy        = scan_ready;
                scan_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
                scan_in    = pat_mem[p][i];
                @(negedge CK);
                if (rdy && scan_valid) i++;
                guard++;
            end
            scan_valid = 1'b0;
            if (i < N_IN) begin
                chk("shift_timeout", 32'(i), 32'(N_IN));
                return;
            end
            want = exp_q.pop_front();
            chk("pi_vec_load", 32'(pi_vec), 32'(want));
            chk("scan_ready_apply", 32'(scan_ready), 32'd0);
            cone_out = cone_mem[p];
            if (p == abort_p) begin
                #2 RN = 1'b0;
                #1;
                chk_reset_values("abort");
                for (int k = 0; k < 3; k++) begin
                    @(negedge CK);
                    chk("abort_no_done", 32'(done), 32'd0);
                end
                RN = 1'b1;
                exp_q.delete();
                return;
            end
            for (int k = 0; k < SETTLE; k++) begin
                if (poke && k == 0) begin
                    start   = 1'b1;
                    num_pat = 16'd0;
                end
                @(negedge CK);
                start   = 1'b0;
                num_pat = 16'(n);
                chk("pi_vec_hold", 32'(pi_vec), 32'(want));
                chk("resp_valid_quiet", 32'(resp_valid), 32'd0);
                chk("busy_apply", 32'(busy), 32'd1);
            end
            @(negedge CK);
            msig = misr_ref(msig, cone_mem[p]);
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_out", 32'(resp_out), 32'(cone_mem[p]));
            chk("pat_cnt", 32'(pat_cnt), 32'(p + 1));
            chk("signature", 32'(signature), 32'(msig));
            chk("pi_vec_after", 32'(pi_vec), 32'(want));
            chk("done_flag", 32'(done), 32'(p == n - 1));
        end
        if (!gap) chk("done_latency", 32'(cyc - c0), 32'(n * (N_IN + SETTLE + 1) + 1));
        @(negedge CK);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("resp_valid_pulse", 32'(resp_valid), 32'd0);
    endtask

    task automatic lfsr_test();
        int c0;
        @(negedge CK);
        start   = 1'b1;
        num_pat = 16'd2;
        c0      = cyc;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CK);
            start = 1'b0;
            chk("lfsr_scan_ready", 32'(scan_ready), 32'd0);
            chk("lfsr_done", 32'(done), 32'(cyc - c0 == 9));
            if (k == 2) chk("lfsr_pat1", 32'(pi_vec), 32'h000001);
            if (k == 6) chk("lfsr_pat2", 32'(pi_vec), 32'h420000);
        end
    endtask

    initial begin
        vecs[0] = '{n: 1, cone: 4'b0001, gap: 1'b0, poke: 1'b0, exp_sig: 16'hB400};
        vecs[1] = '{n: 2, cone: 4'b0001, gap: 1'b0, poke: 1'b0, exp_sig: 16'h5A00};
        vecs[2] = '{n: 1, cone: 4'b0000, gap: 1'b1, poke: 1'b0, exp_sig: 16'h0000};
        vecs[3] = '{n: 2, cone: 4'b0011, gap: 1'b1, poke: 1'b1, exp_sig: 16'hEE00};
        vecs[4] = '{n: 3, cone: 4'b0101, gap: 1'b0, poke: 1'b0, exp_sig: 16'h9900};
        vecs[5] = '{n: 2, cone: 4'b0010, gap: 1'b0, poke: 1'b1, exp_sig: 16'hB400};

        repeat (2) @(negedge CK);
        chk_reset_values("reset");
        RN = 1'b1;

`ifdef BIST_LFSR_EN
        lfsr_test();
`else
        for (int t = 0; t < 6; t++) begin
            for (int p = 0; p < 8; p++) begin
                pat_mem[p]  = N_IN'($urandom);
                cone_mem[p] = (p < 4) ? vecs[t].cone[p] : 1'b0;
            end
            if (t == 2) pat_mem[0] = 23'h123456;
            run_session(vecs[t].n, vecs[t].gap, vecs[t].poke, -1);
            chk("table_sig", 32'(signature), 32'(vecs[t].exp_sig));
            chk("table_cnt", 32'(pat_cnt), 32'(vecs[t].n));
        end

        // zero-pattern session straight after a non-seed signature
        @(negedge CK);
        start   = 1'b1;
        num_pat = 16'd0;
        @(negedge CK);
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_sig", 32'(signature), 32'(SEED));
        chk("zero_scan_ready", 32'(scan_ready), 32'd0);
        @(negedge CK);
        chk("zero_done_end", 32'(done), 32'd0);
        chk("zero_scan_ready_end", 32'(scan_ready), 32'd0);
        chk("zero_busy_end", 32'(busy), 32'd0);

        // reset during APPLY of the third pattern, then a clean single session
        for (int p = 0; p < 8; p++) begin
            pat_mem[p]  = N_IN'($urandom);
            cone_mem[p] = 1'b1;
        end
        run_session(4, 1'b0, 1'b0, 2);
        chk_reset_values("post_abort");
        run_session(1, 1'b0, 1'b0, -1);
        chk("post_abort_sig", 32'(signature), 32'hB400);

        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < 8; p++) begin
                pat_mem[p]  = N_IN'($urandom);
                cone_mem[p] = 1'($urandom_range(0, 1));
            end
            run_session(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), -1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
